// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - two-channel H-bridge PWM driver with duty latching, ramping and reversal dead time
module motor_pwm_driver #(
  parameter int PRESCALE     = 4,
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 4
) (
  input  logic       clk_3125KHz,
  input  logic       reset,
  input  logic       enable,
  input  logic       m1_a,
  input  logic       m1_b,
  input  logic       m2_a,
  input  logic       m2_b,
  input  logic [4:0] dc1,
  input  logic [4:0] dc2,
  output logic       m1_in1,
  output logic       m1_in2,
  output logic       m2_in1,
  output logic       m2_in2,
  output logic [4:0] applied_dc1,
  output logic [4:0] applied_dc2,
  output logic       period_start
);

  localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_MAX   = PW'(PRESCALE - 1);
  localparam int             DW        = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DW-1:0]  DEAD_INIT = (DEAD_PERIODS > 0) ? DW'(DEAD_PERIODS - 1) : '0;
  // Steps of 32 or more saturate the same way, so clamp to keep the 6-bit sum exact.
  localparam logic [5:0]     STEP6     = (RAMP_STEP > 31) ? 6'd32 : 6'(RAMP_STEP);

  typedef enum logic [1:0] {DIR_COAST, DIR_FWD, DIR_REV} dir_t;
  typedef enum logic {ST_RUN, ST_DEAD} state_t;

  logic [PW-1:0] pre_cnt;
  logic [4:0]    pwm_cnt;
  logic          boundary;

  dir_t          req      [2];
  logic [4:0]    target   [2];
  logic [4:0]    ramp_up  [2];
  logic [4:0]    ramp_new [2];
  dir_t          dir      [2];
  state_t        state    [2];
  logic [4:0]    applied  [2];
  logic [DW-1:0] dead_cnt [2];
  logic [1:0]    in1_q;
  logic [1:0]    in2_q;

  // 11 is an illegal request and is treated like 00 (coast).
  function automatic dir_t decode(input logic a, input logic b);
    case ({a, b})
      2'b10:   decode = DIR_FWD;
      2'b01:   decode = DIR_REV;
      default: decode = DIR_COAST;
    endcase
  endfunction

  // Acceleration is limited to STEP6 per period; deceleration takes effect at once.
  function automatic logic [4:0] ramp(input logic [4:0] cur, input logic [4:0] tgt);
    logic [5:0] sum;
    sum = {1'b0, cur} + STEP6;
    if (STEP6 == 6'd0 || tgt <= cur) ramp = tgt;
    else if (sum > {1'b0, tgt})      ramp = tgt;
    else                             ramp = sum[4:0];
  endfunction

  assign boundary = (pwm_cnt == 5'd31) && (pre_cnt == PRE_MAX);

  assign req[0]      = decode(m1_a, m1_b);
  assign req[1]      = decode(m2_a, m2_b);
  assign target[0]   = dc1;
  assign target[1]   = dc2;
  assign ramp_up[0]  = ramp(applied[0], dc1);
  assign ramp_up[1]  = ramp(applied[1], dc2);
  assign ramp_new[0] = ramp(5'd0, dc1);
  assign ramp_new[1] = ramp(5'd0, dc2);

  assign m1_in1      = in1_q[0];
  assign m1_in2      = in2_q[0];
  assign m2_in1      = in1_q[1];
  assign m2_in2      = in2_q[1];
  assign applied_dc1 = applied[0];
  assign applied_dc2 = applied[1];

  // Shared timebase: prescaler, 5-bit PWM counter and period-start pulse; enable does not stop it.
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      // Counters are 0/0 right after the boundary edge, so the pulse is the registered boundary.
      period_start <= boundary;
      if (pre_cnt == PRE_MAX) begin
        pre_cnt <= '0;
        pwm_cnt <= pwm_cnt + 5'd1;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  // Per-channel direction/dead-time FSM and registered H-bridge outputs; commands only move at the boundary.
  always_ff @(posedge clk_3125KHz) begin
    for (int c = 0; c < 2; c++) begin
      if (reset || !enable) begin
        state[c]    <= ST_RUN;
        dir[c]      <= DIR_COAST;
        applied[c]  <= '0;
        dead_cnt[c] <= '0;
        in1_q[c]    <= 1'b0;
        in2_q[c]    <= 1'b0;
      end else begin
        // dir is one-hot across FWD/REV, so in1 and in2 can never both be set.
        in1_q[c] <= (dir[c] == DIR_FWD) && (pwm_cnt < applied[c]);
        in2_q[c] <= (dir[c] == DIR_REV) && (pwm_cnt < applied[c]);
        if (boundary) begin
          case (state[c])
            ST_RUN: begin
              if (req[c] == DIR_COAST) begin
                dir[c]     <= DIR_COAST;
                applied[c] <= '0;
              end else if (dir[c] == DIR_COAST) begin
                dir[c]     <= req[c];
                applied[c] <= ramp_new[c];
              end else if (req[c] == dir[c]) begin
                applied[c] <= ramp_up[c];
              end else if (DEAD_PERIODS > 0) begin
                state[c]    <= ST_DEAD;
                dir[c]      <= DIR_COAST;
                applied[c]  <= '0;
                dead_cnt[c] <= DEAD_INIT;
              end else begin
                dir[c]     <= req[c];
                applied[c] <= ramp_new[c];
              end
            end
            ST_DEAD: begin
              if (dead_cnt[c] != '0) begin
                dead_cnt[c] <= dead_cnt[c] - DW'(1);
              end else begin
                state[c]   <= ST_RUN;
                dir[c]     <= req[c];
                applied[c] <= (req[c] == DIR_COAST) ? 5'd0 : ramp_new[c];
              end
            end
            default: begin
              state[c]   <= ST_RUN;
              dir[c]     <= DIR_COAST;
              applied[c] <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - directed self-checking bench for motor_pwm_driver
module tb_motor_pwm_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       m1_a, m1_b, m2_a, m2_b;
  logic [4:0] dc1, dc2;
  logic       m1_in1, m1_in2, m2_in1, m2_in2;
  logic [4:0] applied_dc1, applied_dc2;
  logic       period_start;

  int total = 0;
  int bad   = 0;
  int h1a, h1b, h2a, h2b, both;

  motor_pwm_driver dut (
    .clk_3125KHz (clk),
    .reset       (reset),
    .enable      (enable),
    .m1_a        (m1_a),
    .m1_b        (m1_b),
    .m2_a        (m2_a),
    .m2_b        (m2_b),
    .dc1         (dc1),
    .dc2         (dc2),
    .m1_in1      (m1_in1),
    .m1_in2      (m1_in2),
    .m2_in1      (m2_in1),
    .m2_in2      (m2_in2),
    .applied_dc1 (applied_dc1),
    .applied_dc2 (applied_dc2),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for the next period_start pulse, sampled on the falling edge.
  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 300);
    check("ps_wait", int'(period_start), 1);
  endtask

  // Count high clocks over one full period, starting at a period_start falling edge.
  task automatic measure(input int chg_at, input logic [4:0] chg_val,
                         output int a1, output int b1, output int a2, output int b2, output int bo);
    a1 = 0; b1 = 0; a2 = 0; b2 = 0; bo = 0;
    for (int n = 1; n <= 128; n++) begin
      @(negedge clk);
      if (n == chg_at) dc1 = chg_val;
      a1 += int'(m1_in1);
      b1 += int'(m1_in2);
      a2 += int'(m2_in1);
      b2 += int'(m2_in2);
      bo += int'((m1_in1 & m1_in2) | (m2_in1 & m2_in2));
    end
    check("period_len", int'(period_start), 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0;
    m1_a = 0; m1_b = 0; m2_a = 0; m2_b = 0; dc1 = 0; dc2 = 0;
    repeat (3) @(negedge clk);
    check("rst_m1_in1", int'(m1_in1), 0);
    check("rst_m1_in2", int'(m1_in2), 0);
    check("rst_m2_in1", int'(m2_in1), 0);
    check("rst_m2_in2", int'(m2_in2), 0);
    check("rst_app1", int'(applied_dc1), 0);
    check("rst_app2", int'(applied_dc2), 0);
    check("rst_ps", int'(period_start), 0);

    // Ramp-up FWD on channel 1 to 16; channel 2 FWD at duty 0 stays low.
    reset = 1'b0; enable = 1'b1;
    m1_a = 1; m1_b = 0; dc1 = 16;
    m2_a = 1; m2_b = 0; dc2 = 0;
    wait_ps();
    for (int i = 1; i <= 4; i++) begin
      check("t1_app1", int'(applied_dc1), 4 * i);
      measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
      check("t1_h1a", h1a, 16 * i);
      check("t1_h1b", h1b, 0);
      check("t1_h2a", h2a, 0);
    end
    check("t1_app1_ss", int'(applied_dc1), 16);
    measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
    check("t1_h1a_ss", h1a, 64);

    // Raise to 20, then reverse; channel 2 ramps to 31 concurrently.
    dc1 = 20; dc2 = 31;
    measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
    check("t2_h1a_p0", h1a, 64);
    check("t2_h2a_p0", h2a, 0);
    check("t2_app1", int'(applied_dc1), 20);
    measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
    check("t2_h1a_p1", h1a, 80);
    check("t2_h2a_p1", h2a, 16);
    m1_a = 0; m1_b = 1;
    measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
    check("t2_h1a_p2", h1a, 80);
    check("t2_h2a_p2", h2a, 32);
    for (int d = 0; d < 2; d++) begin
      check("t2_dead_app1", int'(applied_dc1), 0);
      measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
      check("t2_dead_h1a", h1a, 0);
      check("t2_dead_h1b", h1b, 0);
      check("t2_dead_h2a", h2a, 48 + 16 * d);
    end
    for (int i = 1; i <= 5; i++) begin
      check("t2_rev_app1", int'(applied_dc1), 4 * i);
      measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
      check("t2_rev_h1b", h1b, 16 * i);
      check("t2_rev_h1a", h1a, 0);
      check("t2_both", both, 0);
      check("t2_h2a", h2a, 4 * ((4 * (i + 4) > 31) ? 31 : 4 * (i + 4)));
      check("t2_h2b", h2b, 0);
    end

    // Illegal 11 request coasts; returning to FWD restarts the ramp.
    m1_a = 1; m1_b = 1;
    measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
    check("t3_h1b_last", h1b, 80);
    check("t3_app1_coast", int'(applied_dc1), 0);
    m1_a = 1; m1_b = 0;
    measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
    check("t3_coast_h1", h1a + h1b, 0);
    check("t3_app1_restart", int'(applied_dc1), 4);
    for (int i = 0; i < 4; i++) measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
    check("t3_app1_back", int'(applied_dc1), 20);

    // Mid-period duty drop at pwm_cnt = 10 only lands at the next boundary.
    measure(40, 5'd8, h1a, h1b, h2a, h2b, both);
    check("t4_h1a_cur", h1a, 80);
    check("t4_app1", int'(applied_dc1), 8);
    measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
    check("t4_h1a_next", h1a, 32);

    // enable low at pwm_cnt = 5 clears outputs on the next clock.
    repeat (20) @(negedge clk);
    check("t5_pre_en_m1", int'(m1_in1), 1);
    check("t5_pre_en_m2", int'(m2_in1), 1);
    enable = 1'b0;
    @(negedge clk);
    check("t5_en_m1_in1", int'(m1_in1), 0);
    check("t5_en_m2_in1", int'(m2_in1), 0);
    check("t5_en_app1", int'(applied_dc1), 0);
    check("t5_en_app2", int'(applied_dc2), 0);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    wait_ps();
    check("t5_en_app1_re", int'(applied_dc1), 4);
    check("t5_en_app2_re", int'(applied_dc2), 4);
    measure(0, 5'd0, h1a, h1b, h2a, h2b, both);
    check("t5_en_h1a", h1a, 16);

    // Reset at pwm_cnt = 5 clears outputs on the next clock.
    repeat (20) @(negedge clk);
    check("t5_pre_rst_m1", int'(m1_in1), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_m1_in1", int'(m1_in1), 0);
    check("t5_rst_m2_in1", int'(m2_in1), 0);
    check("t5_rst_app1", int'(applied_dc1), 0);
    check("t5_rst_ps", int'(period_start), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_ps();
    check("t5_rst_app1_re", int'(applied_dc1), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
